// File: rtl/fp_seq_pkg.sv
// fp_seq_pkg: shared opcodes, FSM states and request record for the fixed-point op sequencer
package fp_seq_pkg;
  localparam int FP_W = 32;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic [1:0]      opcode;
  } fp_req_t;
endpackage

// File: rtl/fp_seq_fifo.sv
// fp_seq_fifo: small synchronous request FIFO with extra-MSB wrap pointers
module fp_seq_fifo
  import fp_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  fp_req_t din,
  output fp_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  fp_req_t mem [DEPTH];
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign head  = mem[rd[AW-1:0]];
  // pointers advance on accepted push/pop; both may happen in one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) wr <= wr + (AW+1)'(1);
      if (pop && !empty) rd <= rd + (AW+1)'(1);
    end
  // storage needs no reset; emptiness is tracked by the pointers
  always_ff @(posedge clk)
    if (push && !full) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: queues requests and issues them one at a time to the fixed-point engine
module fp_op_sequencer
  import fp_seq_pkg::*;
#(
  parameter int DATA_W  = FP_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_opcode,
  output logic [DATA_W-1:0] eng_a,
  output logic [DATA_W-1:0] eng_b,
  output logic [1:0]        eng_opcode,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_opcode,
  output logic              out_err
);
  localparam int CW = $clog2(TIMEOUT);
  seq_state_t state, state_nx;
  fp_req_t req_in, head;
  logic full, empty, pop, limit;
  logic [CW-1:0] cnt;
  assign req_in     = '{a: in_a, b: in_b, opcode: in_opcode};
  assign in_ready   = !full;
  assign pop        = state == IDLE && !empty;
  assign limit      = cnt == CW'(TIMEOUT - 1);
  assign out_opcode = eng_opcode;
  fp_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop),
    .din   (req_in),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state; done is only honoured in WAIT, where it beats the timeout
  always_comb
    case (state)
      IDLE:    state_nx = empty ? IDLE : (head.opcode == OP_RSVD ? RESP : ISSUE);
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (eng_done || limit) ? RESP : WAIT;
      default: state_nx = out_ready ? IDLE : RESP;
    endcase
  // state-decoded handshake outputs
  always_comb begin
    eng_start = state == ISSUE;
    out_valid = state == RESP;
  end
  // operands latch on pop and hold until the next pop; result latches when WAIT ends
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      eng_a      <= '0;
      eng_b      <= '0;
      eng_opcode <= OP_ADD;
      out_data   <= '0;
      out_err    <= 1'b0;
      cnt        <= '0;
    end else begin
      cnt <= (state == WAIT) ? cnt + CW'(1) : '0;
      if (pop) begin
        eng_a      <= head.a;
        eng_b      <= head.b;
        eng_opcode <= head.opcode;
        out_data   <= '0;
        out_err    <= head.opcode == OP_RSVD;
      end
      if (state == WAIT && (eng_done || limit)) begin
        out_data <= eng_done ? eng_c : '0;
        out_err  <= !eng_done;
      end
    end
endmodule

// File: tb/tb_fp_op_sequencer.sv
// tb_fp_op_sequencer: directed and random checks of the op sequencer against a queue model
module tb_fp_op_sequencer;
  import fp_seq_pkg::*;
  localparam int TO = 64;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  op;
    logic        e;
  } rsp_t;

  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, out_ready = 1;
  logic [31:0] in_a = 0, in_b = 0;
  logic [1:0]  in_opcode = 0;
  logic [31:0] eng_a, eng_b, eng_c, out_data;
  logic [1:0]  eng_opcode, out_opcode;
  logic        eng_start, eng_done, out_valid, out_err;

  int n_chk = 0, n_fail = 0;
  int n_start = 0, n_rsp = 0, cyc = 0;
  int push_cyc = 0, start_cyc = 0, ov_cyc = 0;
  int cur_lat = 0;
  rsp_t q[$];
  int   lat_q[$];
  logic held = 0;
  logic [31:0] sa, sb;
  logic [1:0]  so;

  // engine model: level done after a per-request latency (-1 = never)
  logic        e_act = 0, late = 0;
  int          e_rem = 0;
  logic [31:0] e_c = 0;

  always #5 clk = ~clk;

  fp_op_sequencer #(.DATA_W(32), .DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .eng_a(eng_a), .eng_b(eng_b), .eng_opcode(eng_opcode), .eng_start(eng_start),
    .eng_done(eng_done), .eng_c(eng_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_opcode(out_opcode), .out_err(out_err)
  );

  function automatic logic [31:0] ref_op(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    logic [63:0] t;
    case (op)
      OP_ADD:  t = 64'(a) + 64'(b);
      OP_MUL:  t = (64'(a) * 64'(b)) >> 16;
      OP_DIV:  t = (b == 0) ? '1 : (64'(a) << 16) / 64'(b);
      default: t = '0;
    endcase
    return t[31:0];
  endfunction

  function automatic rsp_t exp_rsp(logic [31:0] a, logic [31:0] b, logic [1:0] op, int lat);
    if (op == OP_RSVD || lat < 0 || lat > TO - 1) return '{32'd0, op, 1'b1};
    return '{ref_op(a, b, op), op, 1'b0};
  endfunction

  always @(posedge clk) begin
    if (eng_start) begin
      e_act <= 1'b1;
      e_rem <= (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      e_c   <= ref_op(eng_a, eng_b, eng_opcode);
    end else if (e_rem > 0) e_rem <= e_rem - 1;
  end
  assign eng_done = (e_act && e_rem == 0) || late;
  assign eng_c    = e_c;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // one clock: score handshakes before the edge, check holds after it
  task automatic tick();
    rsp_t r;
    logic hs_o, ps, pov, prev_ov, pe;
    logic [31:0] pd;
    hs_o = out_valid && out_ready;
    if (hs_o) begin
      held = 0;
      if (q.size() == 0) chk("unexpected_rsp", {63'd0, out_valid}, 64'd0);
      else begin
        r = q.pop_front();
        chk("rsp_data", out_data, r.d);
        chk("rsp_op", out_opcode, r.op);
        chk("rsp_err", out_err, r.e);
        n_rsp++;
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(exp_rsp(in_a, in_b, in_opcode, cur_lat));
      if (in_opcode != OP_RSVD) lat_q.push_back(cur_lat);
      push_cyc = cyc;
    end
    ps = eng_start; prev_ov = out_valid; pov = out_valid && !hs_o;
    pd = out_data; pe = out_err;
    @(posedge clk); #1;
    cyc++;
    if (ps) chk("start_pulse", eng_start, 0);
    if (pov) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, pd);
      chk("hold_err", out_err, pe);
    end
    if (held && !eng_start) begin
      chk("hold_a", eng_a, sa);
      chk("hold_b", eng_b, sb);
      chk("hold_op", eng_opcode, so);
    end
    if (eng_start) begin
      held = 1; sa = eng_a; sb = eng_b; so = eng_opcode;
      start_cyc = cyc; n_start++;
    end
    if (out_valid && !prev_ov) ov_cyc = cyc;
  endtask

  task automatic push_one(logic [31:0] a, logic [31:0] b, logic [1:0] op, int lat);
    logic ok;
    ok = 0;
    in_valid = 1; in_a = a; in_b = b; in_opcode = op; cur_lat = lat;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 0;
    chk("push_accept", ok, 1);
  endtask

  task automatic wait_idle(int bound);
    for (int i = 0; i < bound && (q.size() > 0 || out_valid); i++) tick();
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    int s0, r0, idx;
    logic [31:0] ba[6], bb[6];
    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", eng_start, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", out_err, 0);
    chk("rst_eng_a", eng_a, 0);
    chk("rst_eng_op", eng_opcode, 0);
    rst_n = 1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // add, zero-latency engine: start at +2, response at +4
    push_one(32'h0080_0000, 32'h0080_0000, OP_ADD, 0);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk("lat_start", start_cyc - push_cyc, 2);
    chk("lat_resp", ov_cyc - push_cyc, 4);
    chk("add_data", out_data, 32'h0100_0000);
    chk("add_err", out_err, 0);
    wait_idle(20);

    // div with a 20-cycle engine
    s0 = n_start; r0 = n_rsp;
    push_one(32'h0060_0000, 32'h0020_0000, OP_DIV, 20);
    wait_idle(100);
    chk("div_starts", n_start - s0, 1);
    chk("div_rsps", n_rsp - r0, 1);

    // reserved opcode never starts the engine
    s0 = n_start;
    push_one(32'h1234_5678, 32'h9abc_def0, OP_RSVD, 0);
    wait_idle(20);
    chk("rsvd_starts", n_start - s0, 0);

    // timeout, then a queued add and a mul whose done coincides with the limit
    push_one(32'h0000_0003, 32'h0000_0005, OP_MUL, -1);
    push_one(32'h0000_0011, 32'h0000_0022, OP_ADD, 0);
    push_one(32'h0003_0000, 32'h0002_0000, OP_MUL, TO - 1);
    for (int i = 0; i < 200 && !out_valid; i++) tick();
    chk("timeout_cycles", ov_cyc - start_cyc, TO + 1);
    chk("timeout_err", out_err, 1);
    out_ready = 0; late = 1;
    tick(); tick();
    late = 0; out_ready = 1;
    wait_idle(300);

    // backpressure: five accepted (four queued, one in flight), then drain in order
    for (int i = 0; i < 6; i++) begin ba[i] = $urandom; bb[i] = $urandom | 1; end
    out_ready = 0; idx = 0; cur_lat = 1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_a = ba[idx]; in_b = bb[idx]; in_opcode = 2'(idx % 3);
      r0 = q.size();
      tick();
      if (q.size() != r0) idx++;
    end
    chk("bp_accepted", idx, 5);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1;
    for (int i = 0; i < 100 && idx < 6; i++) begin
      in_valid = 1; in_a = ba[idx]; in_b = bb[idx]; in_opcode = 2'(idx % 3);
      r0 = q.size();
      tick();
      if (q.size() != r0) idx++;
    end
    in_valid = 0;
    chk("bp_all_pushed", idx, 6);
    wait_idle(200);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      in_a      = $urandom;
      in_b      = $urandom | 1;
      in_opcode = 2'($urandom);
      cur_lat   = int'($urandom_range(0, 5));
      out_ready = ($urandom % 4) != 0;
      tick();
    end
    in_valid = 0; out_ready = 1;
    wait_idle(1000);

    // asynchronous reset in the middle of a div with one more queued
    push_one(32'h0060_0000, 32'h0020_0000, OP_DIV, 20);
    push_one(32'h0000_0001, 32'h0000_0002, OP_ADD, 0);
    for (int i = 0; i < 8; i++) tick();
    #3 rst_n = 0;
    #1;
    q.delete(); lat_q.delete(); held = 0;
    chk("arst_start", eng_start, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_eng_a", eng_a, 0);
    chk("arst_eng_b", eng_b, 0);
    chk("arst_eng_op", eng_opcode, 0);
    chk("arst_data", out_data, 0);
    chk("arst_err", out_err, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;
    s0 = n_start; r0 = n_rsp;
    for (int i = 0; i < 40; i++) tick();
    chk("arst_no_start", n_start - s0, 0);
    chk("arst_no_rsp", n_rsp - r0, 0);
    push_one(32'h0000_0100, 32'h0000_0200, OP_ADD, 2);
    wait_idle(30);
    chk("arst_recover", n_rsp - r0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_op_sequencer.md
Name: fp_op_sequencer

Overview:
- Upstream issue stage for the fixed-point arithmetic top (add/mul/div engine with `a`, `b`, `opcode`, `start`, `c`, `done_flag`).
- Buffers operation requests from a valid/ready producer in a small FIFO and issues them one at a time to the engine.
- Holds operands stable while the engine works, waits for completion or a timeout, then presents the result on a valid/ready response port.
- Makes the engine's level-style done signal safe for streaming use.

Parameters:
- DATA_W, 32: operand/result width.
- DEPTH, 4: request FIFO entries; power of two, ≥ 2.
- TIMEOUT, 64: maximum WAIT cycles before abort; ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  FIFO can accept a request.
- in_a  in  DATA_W  operand a.
- in_b  in  DATA_W  operand b.
- in_opcode  in  2  00 add, 01 mul, 10 div, 11 reserved.
- eng_a  out  DATA_W  operand to engine.
- eng_b  out  DATA_W  operand to engine.
- eng_opcode  out  2  opcode to engine.
- eng_start  out  1  single-cycle issue pulse.
- eng_done  in  1  engine completion flag.
- eng_c  in  DATA_W  engine result.
- out_valid  out  1  response valid.
- out_ready  in  1  consumer accepts response.
- out_data  out  DATA_W  result; 0 on error.
- out_opcode  out  2  opcode of this response.
- out_err  out  1  reserved opcode or timeout.

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty; state IDLE; timeout counter 0.
  - eng_start=0; eng_a, eng_b, eng_opcode = 0.
  - out_valid=0, out_data=0, out_opcode=0, out_err=0.
  - in_ready=1 once reset deasserts.
  - Reset mid-operation drops every queued and in-flight request; no response is produced for them.
- Input side:
  - in_ready = FIFO not full.
  - A push occurs on a rising edge when in_valid && in_ready.
  - Push and pop may occur in the same cycle. There is no empty-FIFO bypass: a pushed entry is visible to the FSM the following cycle.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty are decided by MSB comparison.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE, FIFO not empty: pop the head into the eng_a/eng_b/eng_opcode registers.
    - Opcode 11: go to RESP with out_err=1, out_data=0. The engine is never started.
    - Otherwise: go to ISSUE.
  - ISSUE: eng_start=1 for exactly this cycle; go to WAIT. eng_done is ignored in this cycle, because the add path's done can be combinationally high.
  - WAIT: eng_start=0; counter increments each cycle.
    - eng_done=1: capture eng_c into out_data, out_err=0, go to RESP.
    - Counter reaches TIMEOUT-1 without done: out_data=0, out_err=1, go to RESP.
    - If done and the timeout limit coincide, done wins.
  - RESP: out_valid=1, with out_data/out_opcode/out_err held stable. On out_valid && out_ready go to IDLE and clear the counter.
- eng_a, eng_b, eng_opcode are held from ISSUE until the next pop; they never change during WAIT or RESP.
- eng_done arriving outside WAIT, including a late done after a timeout, is ignored.
- Latency: request accepted at edge n → eng_start high in cycle n+2 → with eng_done high in the first WAIT cycle, out_valid is high in cycle n+4.
- Throughput: one operation per (4 + engine latency) cycles when out_ready is held high.
- Responses are returned strictly in request order.

Decomposition:
- Shared package fp_seq_pkg:
  - Opcode localparams OP_ADD=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_RSVD=2'b11.
  - State enum seq_state_t {IDLE, ISSUE, WAIT, RESP}.
  - Packed struct fp_req_t {a, b, opcode}.
- One sub-module, fp_seq_fifo:
  - Parameterised sync FIFO of fp_req_t.
  - Async active-low reset.
  - Outputs full, empty, and the head entry.

Test Plan:
- Add with a zero-latency engine model: push a=0x00800000, b=0x00800000, op=00; model returns a+b with done high immediately → eng_start pulse exactly 1 cycle, out_valid in cycle n+4, out_data=0x01000000, out_err=0.
- Div with a 20-cycle engine model: push a=0x00600000, b=0x00200000, op=10 → eng_a/eng_b stable for all 20 WAIT cycles, out_data=model quotient, exactly one response.
- Reserved opcode: push op=11 → no eng_start; out_valid with out_err=1, out_data=0, out_opcode=11.
- Timeout: engine never asserts done, TIMEOUT=64 → out_err=1 after 64 WAIT cycles; a late eng_done pulse is ignored; the next queued op issues normally.
- Backpressure/full: hold out_ready=0 and push 6 requests with DEPTH=4 → in_ready drops after the 4th FIFO entry (5 accepted, one in flight). Release out_ready → all 5 responses return in order with matching opcodes.
- Reset mid-WAIT: assert rst_n low during a div → all outputs 0 immediately (async), FIFO empty, no stale response after release.
